uart_rx_core: RTL and testbench

Parametrised UART receive engine that replaces the fixed 8-bit receive controller/shift/count trio with one block. It consumes an external oversampling tick and supports configurable data width, optional parity and 1 or 2 stop bits. It validates the start bit, samples each bit at mid-point and reports parity/framing errors. It sits between the baud tick generator and the receive FIFO/display logic.

---
 rtl/uart_rx_core.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receive engine: start-bit validation, mid-bit sampling, optional parity,
// 1 or 2 stop bits, with break-hold so a held-low line cannot retrigger frames.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int              CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   TCNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   TCNT_ONE  = CW'(1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  function automatic logic parity_mismatch_f(input logic xor_data, input logic sample,
                                             input logic odd);
    return ((xor_data ^ sample) != odd);
  endfunction

  logic                 rx_meta_q;
  logic                 rxs_q;
  state_t               state_q;
  logic [CW-1:0]        tcnt_q;
  logic [3:0]           bcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 xor_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 data_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 busy_q;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receive FSM with registered outputs; counters only advance on tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tcnt_q       <= TCNT_ZERO;
      bcnt_q       <= 4'd0;
      shift_q      <= {DATA_BITS{1'b0}};
      xor_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_out_q   <= {DATA_BITS{1'b0}};
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            tcnt_q  <= TCNT_ZERO;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (tcnt_q == HALF_LAST) begin
              if (!rxs_q) begin
                tcnt_q  <= TCNT_ZERO;
                bcnt_q  <= 4'd0;
                xor_q   <= 1'b0;
                state_q <= S_DATA;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              tcnt_q <= tcnt_q + TCNT_ONE;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tcnt_q == FULL_LAST) begin
              tcnt_q  <= TCNT_ZERO;
              shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
              xor_q   <= xor_q ^ rxs_q;
              if (bcnt_q == DATA_LAST) begin
                bcnt_q  <= 4'd0;
                state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + TCNT_ONE;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            if (tcnt_q == FULL_LAST) begin
              tcnt_q  <= TCNT_ZERO;
              perr_q  <= parity_mismatch_f(xor_q, rxs_q, PAR_ODD);
              state_q <= S_STOP;
            end else begin
              tcnt_q <= tcnt_q + TCNT_ONE;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tcnt_q == FULL_LAST) begin
              tcnt_q <= TCNT_ZERO;
              ferr_q <= ferr_q | ~rxs_q;
              if (bcnt_q == STOP_LAST) begin
                bcnt_q  <= 4'd0;
                state_q <= S_DONE;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + TCNT_ONE;
            end
          end
        end
        S_DONE: begin
          data_out_q   <= shift_q;
          parity_err_q <= perr_q;
          frame_err_q  <= ferr_q;
          data_valid_q <= 1'b1;
          // A line still low here is a break, not a new start bit.
          if (rxs_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (rxs_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three instances (8N1, 8E1, 7N2) share clock, reset
// and tick; frames are table-driven and checked through per-instance scoreboards.
module tb_uart_rx_core;

  localparam int OS = 16;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    int         nbits;
    logic       pen;
    logic       pbit;
    logic       s0;
    logic       s1;
    int         nstop;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } rec_t;

  logic clk, rst, tick;
  logic rx_a, rx_b, rx_c;
  logic [7:0] dout_a, dout_b;
  logic [6:0] dout_c;
  logic dv_a, dv_b, dv_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  rec_t tbl [11];
  logic [8:0] last_a;

  uart_rx_core u_a (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_a), .data_out(dout_a), .data_valid(dv_a),
    .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a)
  );

  uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_b), .data_out(dout_b), .data_valid(dv_b),
    .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b)
  );

  uart_rx_core #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_c), .data_out(dout_c), .data_valid(dv_c),
    .parity_err(pe_c), .frame_err(fe_c), .busy(busy_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk tick every fourth clock.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input int which, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    int   sz;
    case (which)
      0: sz = q_a.size();
      1: sz = q_b.size();
      default: sz = q_c.size();
    endcase
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_valid[%0d]: got data 0x%0h with no frame expected at %0t",
               which, d, $time);
    end else begin
      case (which)
        0: e = q_a.pop_front();
        1: e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
      chk($sformatf("data_out[%0d]", which), {23'd0, d}, {23'd0, e.d});
      chk($sformatf("parity_err[%0d]", which), {31'd0, pe}, {31'd0, e.pe});
      chk($sformatf("frame_err[%0d]", which), {31'd0, fe}, {31'd0, e.fe});
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (dv_a === 1'b1) pop_check(0, {1'b0, dout_a}, pe_a, fe_a);
    if (dv_b === 1'b1) pop_check(1, {1'b0, dout_b}, pe_b, fe_b);
    if (dv_c === 1'b1) pop_check(2, {2'b0, dout_c}, pe_c, fe_c);
  end

  function automatic logic get_busy(input int which);
    case (which)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic int q_size(input int which);
    case (which)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic push_exp(input int which, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    case (which)
      0: begin q_a.push_back(e); last_a = d; end
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    #1;
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_rx(which, v);
    wait_ticks(OS);
  endtask

  task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                            input logic pen, input logic pbit, input logic s0,
                            input logic s1, input int nstop);
    drive_bit(which, 1'b0);
    #1 chk($sformatf("busy_in_frame[%0d]", which), {31'd0, get_busy(which)}, 32'd1);
    for (int i = 0; i < nbits; i++) drive_bit(which, d[i]);
    if (pen) drive_bit(which, pbit);
    drive_bit(which, s0);
    if (nstop == 2) drive_bit(which, s1);
  endtask

  task automatic wait_drain(input int which);
    int budget;
    budget = 400;
    while (q_size(which) != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1 chk($sformatf("pending_frames[%0d]", which), q_size(which), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dout_a"}, {24'd0, dout_a}, 32'd0);
    chk({tag, "_dout_b"}, {24'd0, dout_b}, 32'd0);
    chk({tag, "_dout_c"}, {25'd0, dout_c}, 32'd0);
    chk({tag, "_ctl_a"}, {28'd0, dv_a, pe_a, fe_a, busy_a}, 32'd0);
    chk({tag, "_ctl_b"}, {28'd0, dv_b, pe_b, fe_b, busy_b}, 32'd0);
    chk({tag, "_ctl_c"}, {28'd0, dv_c, pe_c, fe_c, busy_c}, 32'd0);
  endtask

  initial begin
    //        sel data    nb pen pbit s0  s1  ns  exp_d   pe   fe
    tbl[0]  = '{0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 9'h0A5, 1'b0, 1'b0};
    tbl[1]  = '{0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 9'h000, 1'b0, 1'b0};
    tbl[2]  = '{0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 9'h0FF, 1'b0, 1'b0};
    tbl[3]  = '{0, 9'h001, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 9'h001, 1'b0, 1'b0};
    tbl[4]  = '{1, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h003, 1'b0, 1'b0};
    tbl[5]  = '{1, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, 9'h003, 1'b1, 1'b0};
    tbl[6]  = '{1, 9'h080, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, 9'h080, 1'b0, 1'b0};
    tbl[7]  = '{1, 9'h0FE, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9'h0FE, 1'b1, 1'b0};
    tbl[8]  = '{1, 9'h055, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1, 9'h055, 1'b0, 1'b1};
    tbl[9]  = '{2, 9'h055, 7, 1'b0, 1'b0, 1'b1, 1'b1, 2, 9'h055, 1'b0, 1'b0};
    tbl[10] = '{2, 9'h07F, 7, 1'b0, 1'b0, 1'b1, 1'b1, 2, 9'h07F, 1'b0, 1'b0};

    rst  = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    last_a = 9'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    wait_ticks(4);

    // Table-driven frames, each followed by one idle bit.
    for (int k = 0; k < 11; k++) begin
      push_exp(tbl[k].sel, tbl[k].exp_d, tbl[k].exp_pe, tbl[k].exp_fe);
      send_frame(tbl[k].sel, tbl[k].data, tbl[k].nbits, tbl[k].pen, tbl[k].pbit,
                 tbl[k].s0, tbl[k].s1, tbl[k].nstop);
      set_rx(tbl[k].sel, 1'b1);
      wait_ticks(OS);
      wait_drain(tbl[k].sel);
      #1 chk($sformatf("busy_idle_after[%0d]", k), {31'd0, get_busy(tbl[k].sel)}, 32'd0);
    end

    // Glitch shorter than half a bit: back to IDLE, data_out untouched.
    set_rx(0, 1'b0);
    wait_ticks(5);
    #1 chk("glitch_busy_high", {31'd0, busy_a}, 32'd1);
    set_rx(0, 1'b1);
    wait_ticks(10);
    #1 chk("glitch_busy_low", {31'd0, busy_a}, 32'd0);
    chk("glitch_data_hold", {24'd0, dout_a}, {23'd0, last_a});

    // Stop bit low followed by a held-low break: one frame, busy until release.
    push_exp(0, 9'h05A, 1'b0, 1'b1);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    wait_ticks(2 * OS);
    #1 chk("break_busy_high", {31'd0, busy_a}, 32'd1);
    wait_drain(0);
    set_rx(0, 1'b1);
    wait_ticks(4);
    #1 chk("break_busy_low", {31'd0, busy_a}, 32'd0);
    wait_ticks(2 * OS);

    // 7N2 back-to-back, then a frame whose second stop bit is low.
    push_exp(2, 9'h055, 1'b0, 1'b0);
    push_exp(2, 9'h02A, 1'b0, 1'b0);
    send_frame(2, 9'h055, 7, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    send_frame(2, 9'h02A, 7, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    set_rx(2, 1'b1);
    wait_ticks(OS);
    wait_drain(2);
    push_exp(2, 9'h011, 1'b0, 1'b1);
    send_frame(2, 9'h011, 7, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    set_rx(2, 1'b1);
    wait_ticks(OS);
    wait_drain(2);

    // Reset during data bit 4 aborts the frame; the next frame is clean.
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1 ^ i[0]);
    set_rx(0, 1'b0);
    wait_ticks(OS / 2);
    @(negedge clk);
    rst  = 1'b0;
    rx_a = 1'b1;
    @(negedge clk);
    check_all_zero("midframe_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_ticks(OS);
    #1 chk("after_reset_dout", {24'd0, dout_a}, 32'd0);
    push_exp(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    set_rx(0, 1'b1);
    wait_ticks(OS);
    wait_drain(0);

    wait_ticks(OS);
    #1 chk("final_queue_a", q_a.size(), 32'd0);
    chk("final_queue_b", q_b.size(), 32'd0);
    chk("final_queue_c", q_c.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
